glb_iact_banked: RTL and testbench
==================================

GLB_IACT_BANKED -- requirements
Module: glb_iact_banked

Interface
REQ-001 Parameters SHALL be:
- DATA_BITWIDTH, 16: word width.
- ADDR_BITWIDTH, 10: word address width; total depth is 2^ADDR_BITWIDTH.
- NUM_BANKS, 4: power of two, at least 2; bank-interleaved single-read-port banks.
- NUM_CH, 3: independent read channels.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rd_req  in  NUM_CH  per-channel read request.
- rd_addr  in  NUM_CH*ADDR_BITWIDTH  packed per-channel address; channel c occupies slice c.
- rd_gnt  out  NUM_CH  combinational grant for this cycle's request.
- rd_valid  out  NUM_CH  registered; data valid.
- rd_data  out  NUM_CH*DATA_BITWIDTH  packed, signed, registered.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_BITWIDTH  write address.
- wr_data  in  DATA_BITWIDTH  signed write data.

Function
REQ-003 The bank index SHALL be addr[log2(NUM_BANKS)-1:0]; the row SHALL be the remaining upper bits.
REQ-004 Each bank SHALL service at most one read per cycle; channels addressing different banks SHALL all be granted in the same cycle.
REQ-005 Each bank SHALL have a round-robin arbiter over the requesting channels that target it; after a grant, that bank's priority pointer SHALL move to the channel after the winner.
REQ-006 Channels that target the same bank and the same address SHALL still be arbitrated individually; reads SHALL NOT be merged.
REQ-007 rd_gnt[c] SHALL be high only when rd_req[c] is high and channel c wins its bank.
REQ-008 A channel that is not granted SHALL hold rd_req and rd_addr stable; the block SHALL NOT queue requests.
REQ-009 Read latency SHALL be 1 cycle: a grant in cycle N SHALL cause rd_valid[c]=1 in N+1, with rd_data[c] holding the stored word.
REQ-010 rd_valid[c] SHALL be 0 in any cycle that follows a cycle with no grant for channel c.
REQ-011 rd_data[c] SHALL hold its last value while rd_valid[c] is 0; no filler pattern SHALL be driven.
REQ-012 Writes SHALL have priority-free access: wr_en writes mem[wr_addr] at the clock edge, independent of reads, and SHALL never stall.
REQ-013 On a same-cycle read and write to the same address, the read SHALL return the old data unless GLB_IACT_FWD_EN is defined (see REQ-018).
REQ-014 Back-to-back grants to one channel SHALL produce rd_valid high on consecutive cycles.

Reset
REQ-015 While reset is high:
- rd_valid SHALL be 0 and rd_data SHALL be 0.
- rd_gnt SHALL be 0.
- All arbiter pointers SHALL be 0.
- Writes SHALL be ignored.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 If reset rises while a read is in flight, the pending rd_valid SHALL be suppressed in the following cycle.

Configuration
REQ-018 With GLB_IACT_FWD_EN defined, a granted read whose address equals wr_addr while wr_en=1 in the same cycle SHALL return wr_data; without the macro it SHALL return the pre-write contents.

Structure
REQ-019 Package glb_pkg SHALL hold the default width, depth, bank and channel constants and a clog2 helper function.
REQ-020 Sub-module glb_rr_arbiter (NUM_CH requesters, one-hot grant, registered pointer) SHALL be instantiated once per bank.

Verification
REQ-021 Write 0x1234 to address 5; one cycle later ch0 reads address 5 -> rd_gnt[0]=1 in the same cycle; next cycle rd_valid[0]=1 and rd_data[0]=0x1234.
REQ-022 ch0, ch1 and ch2 read addresses 0, 1 and 2 (banks 0, 1, 2) in the same cycle -> all three granted; all three valid one cycle later.
REQ-023 ch0, ch1 and ch2 continuously request addresses 4, 8 and 12 (all bank 0) -> grants rotate ch0, ch1, ch2, ch0; each request is held until granted.
REQ-024 Write 0x00AA to address 7, then write 0x0055 to address 7 while ch1 reads address 7 in the same cycle -> returns 0x00AA without the macro and 0x0055 with GLB_IACT_FWD_EN.
REQ-025 Grant ch2 in cycle N, then assert reset in N+1 -> rd_valid[2]=0 and rd_data=0 in N+1; after reset deasserts, an earlier write to address 3 still reads back intact.
REQ-026 wr_en asserted during reset to address 9 with value 0xFFFF -> a later read of address 9 returns the pre-reset contents.

Source files
------------

// File: rtl/glb_pkg.sv
// Shared defaults for the banked input-activation global buffer.
// Holds the width/depth/bank/channel constants and a constant-evaluable clog2.
package glb_pkg;

    localparam int DEFAULT_DATA_BITWIDTH = 16;
    localparam int DEFAULT_ADDR_BITWIDTH = 10;
    localparam int DEFAULT_NUM_BANKS     = 4;
    localparam int DEFAULT_NUM_CH        = 3;

    // Bounded loop so it elaborates as a constant function in every tool.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/glb_rr_arbiter.sv
// Round-robin arbiter: N requesters, combinational one-hot grant, registered pointer.
// After a grant the pointer moves to the requester following the winner.
module glb_rr_arbiter
    import glb_pkg::*;
#(
    parameter int N = DEFAULT_NUM_CH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic          found;
    int            idx;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/glb_iact_banked.sv
// Bank-interleaved input-activation buffer: NUM_CH read channels, one write port, 1-cycle reads.
// Optional macro GLB_IACT_FWD_EN forwards same-cycle write data to a matching granted read.
module glb_iact_banked
    import glb_pkg::*;
#(
    parameter int DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH,
    parameter int NUM_BANKS     = DEFAULT_NUM_BANKS,
    parameter int NUM_CH        = DEFAULT_NUM_CH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic        [NUM_CH-1:0]               rd_req,
    input  logic        [NUM_CH*ADDR_BITWIDTH-1:0] rd_addr,
    output logic        [NUM_CH-1:0]               rd_gnt,
    output logic        [NUM_CH-1:0]               rd_valid,
    output logic signed [NUM_CH*DATA_BITWIDTH-1:0] rd_data,
    input  logic                                   wr_en,
    input  logic        [ADDR_BITWIDTH-1:0]        wr_addr,
    input  logic signed [DATA_BITWIDTH-1:0]        wr_data
);

    localparam int BANK_W = clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_BITWIDTH - BANK_W;
    localparam int ROWS   = 1 << ROW_W;

    logic [DATA_BITWIDTH-1:0] mem [NUM_BANKS][ROWS];

    logic [BANK_W-1:0]        ch_bank    [NUM_CH];
    logic [ROW_W-1:0]         ch_row     [NUM_CH];
    logic [NUM_CH-1:0]        bank_req   [NUM_BANKS];
    logic [NUM_CH-1:0]        bank_gnt   [NUM_BANKS];
    logic [ROW_W-1:0]         sel_row    [NUM_BANKS];
    logic [DATA_BITWIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [DATA_BITWIDTH-1:0] ch_rdata   [NUM_CH];
    logic [DATA_BITWIDTH-1:0] data_q     [NUM_CH];
    logic [NUM_CH-1:0]        valid_q;
    logic [NUM_CH-1:0]        gnt_any;

    // Low address bits pick the bank, the rest pick the row inside it.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_bank[c] = rd_addr[c*ADDR_BITWIDTH +: BANK_W];
            ch_row[c]  = rd_addr[c*ADDR_BITWIDTH+BANK_W +: ROW_W];
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req[b] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                bank_req[b][c] = rd_req[c] && (ch_bank[c] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_arb
        glb_rr_arbiter #(.N(NUM_CH)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (bank_req[b]),
            .gnt   (bank_gnt[b])
        );
    end

    // Each bank has a single read port driven by the row of its winning channel.
    always_comb begin
        gnt_any = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_any    = gnt_any | bank_gnt[b];
            sel_row[b] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bank_gnt[b][c]) sel_row[b] = ch_row[c];
            end
            bank_rdata[b] = mem[b][sel_row[b]];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rdata[c] = bank_rdata[ch_bank[c]];
`ifdef GLB_IACT_FWD_EN
            if (wr_en && (wr_addr == rd_addr[c*ADDR_BITWIDTH +: ADDR_BITWIDTH])) begin
                ch_rdata[c] = wr_data;
            end
`endif
        end
    end

    assign rd_gnt = gnt_any & ~{NUM_CH{reset}};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
        end else begin
            valid_q <= gnt_any;
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt_any[c]) data_q[c] <= ch_rdata[c];
            end
        end
    end

    // NOTE: the storage array has no reset branch; contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr[BANK_W-1:0]][wr_addr[ADDR_BITWIDTH-1:BANK_W]] <= wr_data;
        end
    end

    // Outputs are forced low combinationally so a read in flight when reset rises never shows.
    assign rd_valid = valid_q & ~{NUM_CH{reset}};

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_data[c*DATA_BITWIDTH +: DATA_BITWIDTH] = reset ? '0 : data_q[c];
        end
    end

endmodule

// File: tb/tb_glb_iact_banked.sv
// Directed self-checking bench for glb_iact_banked (default parameters).
// Honours GLB_IACT_FWD_EN for the same-cycle read/write expectation.
module tb_glb_iact_banked;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NC = 3;

    logic                 clk;
    logic                 reset;
    logic [NC-1:0]        rd_req;
    logic [NC*AW-1:0]     rd_addr;
    logic [NC-1:0]        rd_gnt;
    logic [NC-1:0]        rd_valid;
    logic signed [NC*DW-1:0] rd_data;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;

    int n_checks = 0;
    int n_fails  = 0;

    glb_iact_banked dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ch_data(input int c);
        return rd_data[c*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        rd_addr[c*AW +: AW] = a;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        rd_req = 3'b111;
        #1;
        n_checks++;
        if (rd_gnt !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_gnt: got %b want 000", rd_gnt);
        end
        tick();
        n_checks++;
        if (rd_valid !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_valid: got %b want 000", rd_valid);
        end
        n_checks++;
        if (rd_data !== '0) begin
            n_fails++;
            $display("FAIL reset_data: got %h want 0", rd_data);
        end
        rd_req = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        write_word(10'd5, 16'h1234);
        rd_req = 3'b001;
        set_addr(0, 10'd5);
        #1;
        n_checks++;
        if (rd_gnt !== 3'b001) begin
            n_fails++;
            $display("FAIL basic_gnt: got %b want 001", rd_gnt);
        end
        tick();
        rd_req = '0;
        n_checks++;
        if (rd_valid !== 3'b001 || ch_data(0) !== 16'h1234) begin
            n_fails++;
            $display("FAIL basic_data: valid %b data %h want 001 1234", rd_valid, ch_data(0));
        end
        tick();
        n_checks++;
        if (rd_valid !== 3'b000 || ch_data(0) !== 16'h1234) begin
            n_fails++;
            $display("FAIL basic_hold: valid %b data %h want 000 1234", rd_valid, ch_data(0));
        end
    endtask

    task automatic test_rr_conflict();
        logic [NC-1:0] exp_gnt [4];
        logic [DW-1:0] exp_val [NC];
        int            won;
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_val = '{16'h0404, 16'h0808, 16'h0C0C};
        write_word(10'd4,  16'h0404);
        write_word(10'd8,  16'h0808);
        write_word(10'd12, 16'h0C0C);
        set_addr(0, 10'd4);
        set_addr(1, 10'd8);
        set_addr(2, 10'd12);
        rd_req = 3'b111;
        #1;
        won = -1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_gnt !== exp_gnt[k]) begin
                n_fails++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", k, rd_gnt, exp_gnt[k]);
            end
            tick();
            won = (k == 3) ? 0 : k;
            n_checks++;
            if (rd_valid !== exp_gnt[k] || ch_data(won) !== exp_val[won]) begin
                n_fails++;
                $display("FAIL rr_data[%0d]: valid %b data %h want %b %h",
                         k, rd_valid, ch_data(won), exp_gnt[k], exp_val[won]);
            end
        end
        rd_req = '0;
        tick();
    endtask

    task automatic test_parallel();
        write_word(10'd0, 16'h1000);
        write_word(10'd1, 16'h2001);
        write_word(10'd2, 16'h3002);
        set_addr(0, 10'd0);
        set_addr(1, 10'd1);
        set_addr(2, 10'd2);
        rd_req = 3'b111;
        #1;
        n_checks++;
        if (rd_gnt !== 3'b111) begin
            n_fails++;
            $display("FAIL par_gnt: got %b want 111", rd_gnt);
        end
        tick();
        rd_req = '0;
        n_checks++;
        if (rd_valid !== 3'b111 || ch_data(0) !== 16'h1000 ||
            ch_data(1) !== 16'h2001 || ch_data(2) !== 16'h3002) begin
            n_fails++;
            $display("FAIL par_data: valid %b data %h want 111 3002_2001_1000", rd_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_same_address();
        // Bank 1 pointer sits at 2 here, so the scan wraps to ch0 first.
        set_addr(0, 10'd5);
        set_addr(1, 10'd5);
        rd_req = 3'b011;
        #1;
        n_checks++;
        if (rd_gnt !== 3'b001) begin
            n_fails++;
            $display("FAIL same_gnt0: got %b want 001", rd_gnt);
        end
        tick();
        rd_req = 3'b010;
        #1;
        n_checks++;
        if (rd_gnt !== 3'b010 || rd_valid !== 3'b001) begin
            n_fails++;
            $display("FAIL same_gnt1: gnt %b valid %b want 010 001", rd_gnt, rd_valid);
        end
        tick();
        rd_req = '0;
        n_checks++;
        if (rd_valid !== 3'b010 || ch_data(1) !== 16'h1234) begin
            n_fails++;
            $display("FAIL same_data: valid %b data %h want 010 1234", rd_valid, ch_data(1));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        write_word(10'd6, 16'h6006);
        rd_req = 3'b100;
        set_addr(2, 10'd2);
        tick();
        set_addr(2, 10'd6);
        #1;
        n_checks++;
        if (rd_valid !== 3'b100 || ch_data(2) !== 16'h3002 || rd_gnt !== 3'b100) begin
            n_fails++;
            $display("FAIL b2b_first: valid %b data %h gnt %b want 100 3002 100",
                     rd_valid, ch_data(2), rd_gnt);
        end
        tick();
        rd_req = '0;
        n_checks++;
        if (rd_valid !== 3'b100 || ch_data(2) !== 16'h6006) begin
            n_fails++;
            $display("FAIL b2b_second: valid %b data %h want 100 6006", rd_valid, ch_data(2));
        end
        tick();
    endtask

    task automatic test_raw_same_cycle();
        logic [DW-1:0] exp_raw;
`ifdef GLB_IACT_FWD_EN
        exp_raw = 16'h0055;
`else
        exp_raw = 16'h00AA;
`endif
        write_word(10'd7, 16'h00AA);
        wr_en   = 1'b1;
        wr_addr = 10'd7;
        wr_data = 16'h0055;
        rd_req  = 3'b010;
        set_addr(1, 10'd7);
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (rd_valid !== 3'b010 || ch_data(1) !== exp_raw) begin
            n_fails++;
            $display("FAIL raw_same: valid %b data %h want 010 %h", rd_valid, ch_data(1), exp_raw);
        end
        tick();
        rd_req = '0;
        n_checks++;
        if (ch_data(1) !== 16'h0055) begin
            n_fails++;
            $display("FAIL raw_after: data %h want 0055", ch_data(1));
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        write_word(10'd3, 16'h3333);
        write_word(10'd9, 16'h0909);
        rd_req = 3'b100;
        set_addr(2, 10'd2);
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (rd_valid !== 3'b000 || rd_data !== '0 || rd_gnt !== 3'b000) begin
            n_fails++;
            $display("FAIL inflight: valid %b data %h gnt %b want 000 0 000", rd_valid, rd_data, rd_gnt);
        end
        rd_req = '0;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 3'b000) begin
            n_fails++;
            $display("FAIL inflight_after: valid %b want 000", rd_valid);
        end
        rd_req = 3'b001;
        set_addr(0, 10'd3);
        tick();
        rd_req = '0;
        n_checks++;
        if (rd_valid !== 3'b001 || ch_data(0) !== 16'h3333) begin
            n_fails++;
            $display("FAIL mem_survives: valid %b data %h want 001 3333", rd_valid, ch_data(0));
        end
        tick();
    endtask

    task automatic test_write_during_reset();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 10'd9;
        wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        reset = 1'b0;
        tick();
        rd_req = 3'b001;
        set_addr(0, 10'd9);
        #1;
        n_checks++;
        if (rd_gnt !== 3'b001) begin
            n_fails++;
            $display("FAIL wr_reset_gnt: got %b want 001", rd_gnt);
        end
        tick();
        rd_req = '0;
        n_checks++;
        if (rd_valid !== 3'b001 || ch_data(0) !== 16'h0909) begin
            n_fails++;
            $display("FAIL wr_reset_data: valid %b data %h want 001 0909", rd_valid, ch_data(0));
        end
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        rd_req  = '0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        test_reset();
        test_basic_read();
        test_rr_conflict();
        test_parallel();
        test_same_address();
        test_back_to_back();
        test_raw_same_cycle();
        test_reset_inflight();
        test_write_during_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
